// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: state, opcode, ALU and fault encodings shared by the multi-cycle sequencer
package mc_ctrl_pkg;
  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, TRAP
  } state_t;
  localparam logic [2:0] OP_RTYPE = 3'b000;
  localparam logic [2:0] OP_LW = 3'b001;
  localparam logic [2:0] OP_SW = 3'b010;
  localparam logic [1:0] ALU_FUNCT = 2'b00;
  localparam logic [1:0] ALU_ADD = 2'b11;
  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_TWO = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;
  localparam logic [1:0] F_NONE = 2'b00;
  localparam logic [1:0] F_ILLEGAL = 2'b01;
  localparam logic [1:0] F_TIMEOUT = 2'b10;
  typedef struct packed {
    logic iord;
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic reg_dst;
    logic mem_to_reg;
    logic src_a;
    logic [1:0] src_b;
    logic [1:0] alu_op;
  } ctl_t;
  function automatic ctl_t decode_ctl(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.mem_read = 1'b1;
        c.src_b = SRCB_TWO;
        c.alu_op = ALU_ADD;
      end
      MEMADR: begin
        c.src_a = 1'b1;
        c.src_b = SRCB_IMM;
        c.alu_op = ALU_ADD;
      end
      MEMRD: begin
        c.mem_read = 1'b1;
        c.iord = 1'b1;
      end
      MEMWB: begin
        c.reg_write = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      MEMWR: begin
        c.mem_write = 1'b1;
        c.iord = 1'b1;
      end
      EXEC: begin
        c.src_a = 1'b1;
        c.src_b = SRCB_REG;
        c.alu_op = ALU_FUNCT;
      end
      ALUWB: begin
        c.reg_write = 1'b1;
        c.reg_dst = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction
endpackage

// File: rtl/mc_wait_timer.sv
// mc_wait_timer: saturating memory wait counter with timeout flag (MEM_TIMEOUT=0 disables)
module mc_wait_timer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic timeout
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + 1'b1;
  assign timeout = (MEM_TIMEOUT != 0) && (cnt == CNT_W'(MEM_TIMEOUT));
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: fetch/decode/execute/memory/writeback sequencer for the 16-bit MIPS core.
// Optional performance counters are built when MC_CTRL_PERF_EN is defined.
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  op,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        RegDst,
  output logic        MemToReg,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [15:0] retired,
  output logic [15:0] stall_cycles
);
  state_t state, nxt;
  ctl_t ctl;
  logic lw_q, mem_state, tmo;
  assign mem_state = state inside {FETCH, MEMRD, MEMWR};
  mc_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .clr(!mem_state || mem_ready),
    .inc(mem_state && !mem_ready),
    .timeout(tmo)
  );
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = FETCH;
      FETCH: nxt = mem_ready ? DECODE : tmo ? TRAP : FETCH;
      DECODE: nxt = (op == OP_RTYPE) ? EXEC : (op == OP_LW || op == OP_SW) ? MEMADR : TRAP;
      MEMADR: nxt = lw_q ? MEMRD : MEMWR;
      MEMRD: nxt = mem_ready ? MEMWB : tmo ? TRAP : MEMRD;
      MEMWB: nxt = FETCH;
      MEMWR: nxt = mem_ready ? FETCH : tmo ? TRAP : MEMWR;
      EXEC: nxt = ALUWB;
      ALUWB: nxt = FETCH;
      TRAP: nxt = TRAP;
      default: nxt = IDLE;
    endcase
  end
  // Moore controls are registered from the next state so they never glitch
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ctl <= '0;
      lw_q <= 1'b0;
      fault <= 1'b0;
      fault_code <= F_NONE;
    end else begin
      state <= nxt;
      ctl <= decode_ctl(nxt);
      fault <= nxt == TRAP;
      if (state == DECODE) lw_q <= op == OP_LW;
      if (nxt == TRAP && state != TRAP) fault_code <= (state == DECODE) ? F_ILLEGAL : F_TIMEOUT;
    end
  assign IRWrite = state == FETCH && mem_ready;
  assign PCWrite = state == FETCH && mem_ready;
  assign IorD = ctl.iord;
  assign MemRead = ctl.mem_read;
  assign MemWrite = ctl.mem_write;
  assign RegWrite = ctl.reg_write;
  assign RegDst = ctl.reg_dst;
  assign MemToReg = ctl.mem_to_reg;
  assign ALUSrcA = ctl.src_a;
  assign ALUSrcB = ctl.src_b;
  assign ALUOp = ctl.alu_op;
`ifdef MC_CTRL_PERF_EN
  logic [15:0] ret_q, stl_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ret_q <= '0;
      stl_q <= '0;
    end else begin
      if (state == MEMWB || state == ALUWB || (state == MEMWR && mem_ready)) ret_q <= ret_q + 16'd1;
      if (mem_state && !mem_ready) stl_q <= stl_q + 16'd1;
    end
  assign retired = ret_q;
  assign stall_cycles = stl_q;
`else
  assign retired = '0;
  assign stall_cycles = '0;
`endif
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: per-cycle vector table generated from instruction-level descriptions
module tb_multicycle_control;
  localparam int TMO = 15;
`ifdef MC_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  // bit order: PCWrite IRWrite IorD MemRead MemWrite RegWrite RegDst MemToReg ALUSrcA ALUSrcB ALUOp fault fault_code
  localparam logic [15:0] V_IDLE = 16'h0000;
  localparam logic [15:0] V_FW = 16'h1038;
  localparam logic [15:0] V_FR = 16'hD038;
  localparam logic [15:0] V_DEC = 16'h0000;
  localparam logic [15:0] V_MA = 16'h00D8;
  localparam logic [15:0] V_MRD = 16'h3000;
  localparam logic [15:0] V_MWB = 16'h0500;
  localparam logic [15:0] V_MWR = 16'h2800;
  localparam logic [15:0] V_EX = 16'h0080;
  localparam logic [15:0] V_AWB = 16'h0600;
  localparam logic [15:0] V_TRAP = 16'h0004;
  logic clk = 1'b0, rst_n = 1'b0, mem_ready = 1'b0;
  logic [2:0] op = 3'b000;
  logic PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, RegDst, MemToReg, ALUSrcA, fault;
  logic [1:0] ALUSrcB, ALUOp, fault_code;
  logic [15:0] retired, stall_cycles, act;
  always #5 clk = ~clk;
  multicycle_control #(.MEM_TIMEOUT(TMO), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .RegDst(RegDst), .MemToReg(MemToReg), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .fault(fault), .fault_code(fault_code),
    .retired(retired), .stall_cycles(stall_cycles)
  );
  assign act = {PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, RegDst, MemToReg,
                ALUSrcA, ALUSrcB, ALUOp, fault, fault_code};
  typedef struct {
    logic rdy;
    logic [2:0] op;
    logic [15:0] exp;
    logic [15:0] ret;
    logic [15:0] stl;
  } vec_t;
  vec_t q[$];
  int errors = 0, checks = 0, n_ret, n_stl;
  bit trapped;
  logic [2:0] cur_op;
  task automatic chk(input string nm, input int k, input logic [15:0] a, input logic [15:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s[%0d] got %h want %h", nm, k, a, e);
    end
  endtask
  function automatic logic rnd();
    return logic'($urandom_range(0, 1));
  endfunction
  task automatic push(input logic rdy, input logic [15:0] e);
    q.push_back('{rdy, cur_op, e, PERF ? 16'(n_ret) : 16'h0, PERF ? 16'(n_stl) : 16'h0});
  endtask
  task automatic trap(input logic [1:0] code);
    for (int i = 0; i < 20; i++) push(rnd(), V_TRAP | {14'b0, code});
    trapped = 1'b1;
  endtask
  // w wait cycles then a ready cycle, or a timeout once w exceeds the limit
  task automatic mem_phase(input int w, input logic [15:0] vw, input logic [15:0] vd);
    for (int i = 0; i < w && i <= TMO; i++) begin
      push(1'b0, vw);
      n_stl++;
    end
    if (w > TMO) trap(2'b10);
    else push(1'b1, vd);
  endtask
  task automatic new_seg();
    q.delete();
    n_ret = 0;
    n_stl = 0;
    trapped = 1'b0;
    cur_op = 3'b000;
    push(rnd(), V_IDLE);
  endtask
  task automatic instr(input logic [2:0] o, input int wf, input int wm);
    if (trapped) return;
    cur_op = o;
    mem_phase(wf, V_FW, V_FR);
    if (trapped) return;
    push(rnd(), V_DEC);
    if (o == 3'b000) begin
      push(rnd(), V_EX);
      push(rnd(), V_AWB);
      n_ret++;
    end else if (o == 3'b001) begin
      push(rnd(), V_MA);
      mem_phase(wm, V_MRD, V_MRD);
      if (!trapped) begin
        push(rnd(), V_MWB);
        n_ret++;
      end
    end else if (o == 3'b010) begin
      push(rnd(), V_MA);
      mem_phase(wm, V_MWR, V_MWR);
      if (!trapped) n_ret++;
    end else trap(2'b01);
  endtask
  task automatic run(input int n);
    rst_n = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < n; k++) begin
      mem_ready = q[k].rdy;
      op = q[k].op;
      @(negedge clk);
      chk("ctl", k, act, q[k].exp);
      chk("retired", k, retired, q[k].ret);
      chk("stall", k, stall_cycles, q[k].stl);
      @(posedge clk);
      #1;
    end
  endtask
  function automatic int rand_wait();
    int r;
    r = int'($urandom_range(0, 19));
    return r < 14 ? r % 4 : r - 2;
  endfunction
  function automatic logic [2:0] rand_op();
    int r;
    r = int'($urandom_range(0, 9));
    return r < 3 ? 3'b000 : r < 6 ? 3'b001 : r < 9 ? 3'b010 : 3'($urandom_range(3, 7));
  endfunction
  initial begin
    new_seg();
    instr(3'b000, 0, 0);
    instr(3'b001, 0, 0);
    instr(3'b010, 0, 0);
    instr(3'b000, 0, 0);
    run(q.size());
    new_seg();
    instr(3'b001, 0, 3);
    instr(3'b000, 0, 0);
    run(q.size());
    new_seg();
    instr(3'b000, 0, 0);
    instr(3'b011, 0, 0);
    run(q.size());
    new_seg();
    instr(3'b000, 16, 0);
    run(q.size());
    new_seg();
    instr(3'b000, 15, 0);
    instr(3'b010, 0, 15);
    instr(3'b001, 0, 16);
    run(q.size());
    for (int s = 0; s < 30; s++) begin
      new_seg();
      for (int i = 0; i < 8; i++) instr(rand_op(), rand_wait(), rand_wait());
      run(q.size());
    end
    new_seg();
    instr(3'b001, 1, 2);
    instr(3'b010, 0, 8);
    run(q.size() - 3);
    mem_ready = 1'b0;
    op = 3'b010;
    #1 chk("wr_before_rst", 0, {15'b0, MemWrite}, 16'h0001);
    rst_n = 1'b0;
    #1 chk("rst_ctl", 0, act, 16'h0000);
    chk("rst_retired", 0, retired, 16'h0000);
    chk("rst_stall", 0, stall_cycles, 16'h0000);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_idle", 0, act, V_IDLE);
    @(posedge clk);
    @(negedge clk);
    chk("rel_fetch", 0, act, V_FW);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
